// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: snapshots per-digit segment
// bytes once per frame and walks them across a shared bus with blanked slots.
module hex_scan_ctrl #(
  parameter int QUANTITY = 8,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16,
  localparam int IDX_W   = (QUANTITY > 1) ? $clog2(QUANTITY) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [QUANTITY*7-1:0] seg_i,
  output logic [6:0]            o_seg,
  output logic [QUANTITY-1:0]   o_dig_n,
  output logic [IDX_W-1:0]      o_scan_idx,
  output logic                  o_frame_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       shadow_q [QUANTITY];
  logic [6:0]       shadow_d [QUANTITY];

  logic slot_end;
  logic last_idx;
  logic blank;
  logic load;

  assign slot_end = (cnt_q == CNT_W'(PRESCALE - 1));
  assign last_idx = (idx_q == IDX_W'(QUANTITY - 1));

  // Blanking window at the start of each slot; absent entirely when BLANK is 0.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (cnt_q < CNT_W'(BLANK));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < QUANTITY; k++) begin
        shadow_q[k] <= 7'h7F;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < QUANTITY; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      SCAN: begin
        if (!en_i) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (slot_end) begin
          cnt_d = '0;
          if (last_idx) begin
            // Frame boundary: the next frame displays a fresh, coherent snapshot.
            idx_d = '0;
            load  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
    for (int k = 0; k < QUANTITY; k++) begin
      shadow_d[k] = load ? seg_i[7*k +: 7] : shadow_q[k];
    end
  end

  always_comb begin
    o_seg        = 7'h7F;
    o_dig_n      = '1;
    o_scan_idx   = idx_q;
    o_frame_done = 1'b0;
    if (state_q == SCAN) begin
      o_frame_done = slot_end && last_idx;
      if (!blank) begin
        o_seg   = shadow_q[idx_q];
        o_dig_n = ~(QUANTITY'(1) << idx_q);
      end
    end
  end

endmodule
